// File: rtl/fib_port_pkg.sv
// Shared definitions for the Fibonacci test-port writer and its result checker,
// so both ends agree on the port address and framing symbols.
package fib_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        PH_BEG,
        PH_UP,
        PH_DOWN,
        PH_END
    } phase_t;

    localparam logic [29:0] TEST_PORT = 30'h40;
    localparam logic [31:0] BEGIN_SYM = 32'h0000_0932;
    localparam logic [31:0] END_SYM   = 32'h0000_0D5D;

    // Word carried by a write in the given phase; UP/DOWN carry the current term.
    function automatic logic [31:0] phase_word(input phase_t ph, input logic [31:0] term);
        case (ph)
            PH_BEG:  return BEGIN_SYM;
            PH_END:  return END_SYM;
            default: return term;
        endcase
    endfunction

endpackage

// File: rtl/fib_step_unit.sv
// Combinational Fibonacci step: forward (a,b)->(b,a+b) or backward (a,b)->(b-a,a).
// Zero latency; no handshake.
module fib_step_unit (
    input  logic        down,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] a_nxt,
    output logic [31:0] b_nxt
);

    always_comb begin
        a_nxt = b;
        b_nxt = a + b;
        if (down) begin
            a_nxt = b - a;
            b_nxt = a;
        end
    end

endmodule

// File: rtl/fib_port_writer.sv
// Bus initiator writing BEGIN, Fibonacci terms up then down, END to the test port.
// Latency: wen rises one cycle after an accepted start; each write is >=1 cycle plus GAP_CYC idle.
// Backpressure: stall freezes the in-flight write; gaps ignore stall. FIB_WRITER_ERR_INJECT_EN adds err_inj.
module fib_port_writer
    import fib_port_pkg::*;
#(
    parameter int N_TERMS = 16,
    parameter int GAP_CYC = 1
`ifdef FIB_WRITER_ERR_INJECT_EN
    ,
    parameter int ERR_IDX = 5
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
`ifdef FIB_WRITER_ERR_INJECT_EN
    input  logic        err_inj,
`endif
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done,
    output logic [5:0]  wr_cnt
);

    state_t      state;
    phase_t      phase;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] a_nxt;
    logic [31:0] b_nxt;
    logic [4:0]  term_idx;
    logic [3:0]  gap_cnt;
    logic        fin_pend;
    logic        last_term;
    logic [31:0] next_word;

`ifdef FIB_WRITER_ERR_INJECT_EN
    logic        err_lat;
`endif

    fib_step_unit u_step (
        .down  (phase == PH_DOWN),
        .a     (a),
        .b     (b),
        .a_nxt (a_nxt),
        .b_nxt (b_nxt)
    );

    assign last_term = (term_idx == 5'(N_TERMS - 1));

    // Word for the write about to be issued; phase and a already reflect the last completion.
    always_comb begin
        next_word = phase_word(phase, a);
`ifdef FIB_WRITER_ERR_INJECT_EN
        if (err_lat && (phase == PH_UP || phase == PH_DOWN) && wr_cnt == 6'(ERR_IDX))
            next_word = next_word ^ 32'd1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            phase    <= PH_BEG;
            addr     <= '0;
            data     <= '0;
            wen      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_cnt   <= '0;
            a        <= '0;
            b        <= 32'd1;
            term_idx <= '0;
            gap_cnt  <= '0;
            fin_pend <= 1'b0;
`ifdef FIB_WRITER_ERR_INJECT_EN
            err_lat  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        state    <= ST_WRITE;
                        phase    <= PH_BEG;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        wr_cnt   <= '0;
                        a        <= '0;
                        b        <= 32'd1;
                        term_idx <= '0;
                        fin_pend <= 1'b0;
                        addr     <= TEST_PORT;
                        data     <= BEGIN_SYM;
                        wen      <= 1'b1;
`ifdef FIB_WRITER_ERR_INJECT_EN
                        err_lat  <= err_inj;
`endif
                    end
                end

                ST_WRITE: begin
                    if (!stall) begin
                        wen     <= 1'b0;
                        wr_cnt  <= wr_cnt + 6'd1;
                        gap_cnt <= 4'(GAP_CYC);
                        state   <= ST_GAP;
                        case (phase)
                            PH_BEG: phase <= PH_UP;
                            PH_UP: begin
                                // Peak term is written twice: turn around without stepping.
                                if (last_term) begin
                                    phase    <= PH_DOWN;
                                    term_idx <= '0;
                                end else begin
                                    a        <= a_nxt;
                                    b        <= b_nxt;
                                    term_idx <= term_idx + 5'd1;
                                end
                            end
                            PH_DOWN: begin
                                if (last_term) begin
                                    phase <= PH_END;
                                end else begin
                                    a        <= a_nxt;
                                    b        <= b_nxt;
                                    term_idx <= term_idx + 5'd1;
                                end
                            end
                            PH_END: fin_pend <= 1'b1;
                            default: ;
                        endcase
                    end
                end

                ST_GAP: begin
                    if (gap_cnt <= 4'd1) begin
                        gap_cnt <= '0;
                        if (fin_pend) begin
                            state    <= ST_FIN;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            fin_pend <= 1'b0;
                        end else begin
                            state <= ST_WRITE;
                            data  <= next_word;
                            wen   <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
